id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter: size, 32, datapath width in bits.
REQ-002 SHALL have ports (name direction width meaning):
  CLK  in  1  clock, rising edge active
  aRST  in  1  asynchronous reset, active-high
  id_valid  in  1  decode slot holds a real instruction
  id_rs1, id_rs2  in  5  source register indices (also drive register bank read ports)
  id_rs1_used, id_rs2_used  in  1  instruction actually reads rs1/rs2
  id_rd  in  5  destination index
  id_regwrite, id_memread  in  1  writes rd / is a load
  id_imm  in  size  decoded immediate
  read_data1, read_data2  in  size  register bank asynchronous read data
  exmem_rd  in  5;  exmem_regwrite, exmem_memread  in  1;  exmem_result  in  size  MEM-stage producer
  memwb_rd  in  5;  memwb_regwrite  in  1;  memwb_result  in  size  WB-stage producer, written to bank at next edge
  flush  in  1  squash decode slot (taken branch)
  stall  out  1  combinational; upstream holds PC and IF/ID when 1
  ex_valid, ex_regwrite, ex_memread  out  1  registered control
  ex_rs1_data, ex_rs2_data, ex_imm  out  size  registered operands
  ex_rd  out  5  registered destination

Function
REQ-003 SHALL register all ex_* outputs at rising CLK; capture latency one cycle.
REQ-004 SHALL define match(P,r): P valid, P writes, P.rd==r, r!=0, source used; EX producer = ex_valid&ex_regwrite&ex_rd.
REQ-005 SHALL assert stall = id_valid & !flush & hazard, hazard per REQ-010/011.
REQ-006 SHALL on flush=1 load bubble: ex_valid=0, ex_regwrite=0, ex_memread=0, ex_rd=0; flush overrides stall.
REQ-007 SHALL on stall=1 load same bubble; upstream re-presents identical id_* next cycle.
REQ-008 SHALL otherwise load id_* fields, ex_valid=id_valid; control bits forced 0 when id_valid=0.
REQ-009 SHALL never stall or forward for register 0; operand for index 0 is 0 regardless of inputs.
REQ-010 (FWD_EN) hazard = match(EX, rs1|rs2) | match(EXMEM & exmem_memread, rs1|rs2).
REQ-011 (no FWD_EN) hazard = match(EX|EXMEM|MEMWB, rs1|rs2).
REQ-012 SHALL select each captured operand by priority: EXMEM forward (non-load match), then MEMWB forward, then read_dataN.
REQ-013 SHALL treat MEMWB match as bypass of same-cycle bank write (bank write not yet visible to asynchronous read).
REQ-014 Stall lasts exactly until producer leaves the hazard window; no internal counters beyond registered state; back-to-back stalls permitted.

Reset
REQ-015 SHALL on aRST=1 immediately clear all ex_* outputs to 0, independent of CLK.
REQ-016 SHALL resume normal capture on first rising CLK after aRST deasserts; stall combinational from inputs and reset state (0 EX producer).

Configuration
REQ-017 SHALL compile forwarding muxes only when macro ID_EX_FORWARD_EN is defined (REQ-010, REQ-012 EXMEM/MEMWB arms).
REQ-018 SHALL without ID_EX_FORWARD_EN pass read_dataN directly and use REQ-011 stall rule; port list unchanged, forward inputs unused.

Verification
REQ-019 Reset: aRST=1 mid-cycle with ex_valid=1 -> all ex_* 0 before next edge, stall=0.
REQ-020 Forward: exmem_rd=5, exmem_regwrite=1, exmem_result=0xAA, memwb_rd=5 result 0xBB, id_rs1=5 -> ex_rs1_data=0xAA (FWD_EN); stall=1 without.
REQ-021 Load-use: ex_memread=1, ex_regwrite=1, ex_rd=7, id_rs2=7 used -> stall=1 one cycle, bubble, then with exmem_memread=1 stall again, then MEMWB forward of 0x1234.
REQ-022 x0: all producers rd=0, id_rs1=0, read_data1=0xFFFF -> ex_rs1_data=0, stall=0.
REQ-023 Flush during stall: hazard active and flush=1 -> stall=0, ex_valid=0 next cycle.
REQ-024 Unused source: id_rs2_used=0, id_rs2 matches EX rd -> stall=0, operand from read_data2.

Source files
------------

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// Decode-to-execute pipeline register with hazard detection and optional
// operand forwarding for a 5-stage in-order pipeline.
//
// Configuration macro: ID_EX_FORWARD_EN
//   defined   : EXMEM/MEMWB forwarding muxes are built. The pipeline stalls
//               only on an EX-stage producer or a load sitting in EXMEM.
//   undefined : operands come straight from the register bank. The pipeline
//               stalls on any in-flight producer (EX, EXMEM or MEMWB). The
//               forwarding inputs are present but ignored.
//
// Ports
//   CLK, aRST                 clock (rising edge), async active-high reset
//   id_*                      decode-slot instruction fields
//   read_data1/2              register bank asynchronous read data
//   exmem_*                   producer currently in MEM
//   memwb_*                   producer currently in WB (bank write pending)
//   flush                     squash the decode slot
//   stall                     combinational hold request to IF/ID and PC
//   ex_*                      registered EX-stage instruction
// -----------------------------------------------------------------------------
module id_ex_stage #(
   parameter int size = 32
) (
   input  logic            CLK,
   input  logic            aRST,
   input  logic            id_valid,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   input  logic            id_rs1_used,
   input  logic            id_rs2_used,
   input  logic [4:0]      id_rd,
   input  logic            id_regwrite,
   input  logic            id_memread,
   input  logic [size-1:0] id_imm,
   input  logic [size-1:0] read_data1,
   input  logic [size-1:0] read_data2,
   input  logic [4:0]      exmem_rd,
   input  logic            exmem_regwrite,
   input  logic            exmem_memread,
   input  logic [size-1:0] exmem_result,
   input  logic [4:0]      memwb_rd,
   input  logic            memwb_regwrite,
   input  logic [size-1:0] memwb_result,
   input  logic            flush,
   output logic            stall,
   output logic            ex_valid,
   output logic            ex_regwrite,
   output logic            ex_memread,
   output logic [size-1:0] ex_rs1_data,
   output logic [size-1:0] ex_rs2_data,
   output logic [size-1:0] ex_imm,
   output logic [4:0]      ex_rd
);

   logic            ex_valid_q,    ex_valid_d;
   logic            ex_regwrite_q, ex_regwrite_d;
   logic            ex_memread_q,  ex_memread_d;
   logic [size-1:0] ex_rs1_data_q, ex_rs1_data_d;
   logic [size-1:0] ex_rs2_data_q, ex_rs2_data_d;
   logic [size-1:0] ex_imm_q,      ex_imm_d;
   logic [4:0]      ex_rd_q,       ex_rd_d;

   logic            hazard;
   logic            bubble;
   logic            ex_prod;
   logic [size-1:0] op1;
   logic [size-1:0] op2;

   // A producer writing register r only matters when the consumer actually
   // reads r and r is not the hard-wired zero register.
   function automatic logic src_match(input logic       prod,
                                      input logic [4:0] prod_rd,
                                      input logic [4:0] r,
                                      input logic       used);
      return prod && (prod_rd == r) && (r != 5'd0) && used;
   endfunction

`ifdef ID_EX_FORWARD_EN
   logic xm_alu;
   logic xm_load;
   logic fwd1_xm, fwd2_xm, fwd1_mw, fwd2_mw;

   always_comb begin
      ex_prod = ex_valid_q & ex_regwrite_q;
      xm_alu  = exmem_regwrite & ~exmem_memread;
      xm_load = exmem_regwrite &  exmem_memread;

      // EX result is not yet available and load data not until WB: stall.
      hazard = src_match(ex_prod, ex_rd_q, id_rs1, id_rs1_used)
             | src_match(ex_prod, ex_rd_q, id_rs2, id_rs2_used)
             | src_match(xm_load, exmem_rd, id_rs1, id_rs1_used)
             | src_match(xm_load, exmem_rd, id_rs2, id_rs2_used);

      fwd1_xm = src_match(xm_alu, exmem_rd, id_rs1, id_rs1_used);
      fwd2_xm = src_match(xm_alu, exmem_rd, id_rs2, id_rs2_used);
      // MEMWB forwarding bypasses the bank write that lands at this edge.
      fwd1_mw = src_match(memwb_regwrite, memwb_rd, id_rs1, id_rs1_used);
      fwd2_mw = src_match(memwb_regwrite, memwb_rd, id_rs2, id_rs2_used);

      if (id_rs1 == 5'd0)  op1 = '0;
      else if (fwd1_xm)    op1 = exmem_result;
      else if (fwd1_mw)    op1 = memwb_result;
      else                 op1 = read_data1;

      if (id_rs2 == 5'd0)  op2 = '0;
      else if (fwd2_xm)    op2 = exmem_result;
      else if (fwd2_mw)    op2 = memwb_result;
      else                 op2 = read_data2;
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{exmem_memread, exmem_result, memwb_result};

   always_comb begin
      ex_prod = ex_valid_q & ex_regwrite_q;
      // Without forwarding every in-flight producer is a hazard until its
      // value is visible through the bank read port.
      hazard = src_match(ex_prod, ex_rd_q, id_rs1, id_rs1_used)
             | src_match(ex_prod, ex_rd_q, id_rs2, id_rs2_used)
             | src_match(exmem_regwrite, exmem_rd, id_rs1, id_rs1_used)
             | src_match(exmem_regwrite, exmem_rd, id_rs2, id_rs2_used)
             | src_match(memwb_regwrite, memwb_rd, id_rs1, id_rs1_used)
             | src_match(memwb_regwrite, memwb_rd, id_rs2, id_rs2_used);
      op1 = (id_rs1 == 5'd0) ? '0 : read_data1;
      op2 = (id_rs2 == 5'd0) ? '0 : read_data2;
   end
`endif

   assign stall  = id_valid & ~flush & hazard;
   assign bubble = flush | stall;

   always_comb begin
      ex_valid_d    = id_valid & ~bubble;
      ex_regwrite_d = id_valid & id_regwrite & ~bubble;
      ex_memread_d  = id_valid & id_memread & ~bubble;
      ex_rd_d       = bubble ? 5'd0 : id_rd;
      ex_rs1_data_d = op1;
      ex_rs2_data_d = op2;
      ex_imm_d      = id_imm;
   end

   always_ff @(posedge CLK or posedge aRST) begin
      if (aRST) begin
         ex_valid_q    <= 1'b0;
         ex_regwrite_q <= 1'b0;
         ex_memread_q  <= 1'b0;
         ex_rd_q       <= 5'd0;
         ex_rs1_data_q <= '0;
         ex_rs2_data_q <= '0;
         ex_imm_q      <= '0;
      end else begin
         ex_valid_q    <= ex_valid_d;
         ex_regwrite_q <= ex_regwrite_d;
         ex_memread_q  <= ex_memread_d;
         ex_rd_q       <= ex_rd_d;
         ex_rs1_data_q <= ex_rs1_data_d;
         ex_rs2_data_q <= ex_rs2_data_d;
         ex_imm_q      <= ex_imm_d;
      end
   end

   assign ex_valid    = ex_valid_q;
   assign ex_regwrite = ex_regwrite_q;
   assign ex_memread  = ex_memread_q;
   assign ex_rd       = ex_rd_q;
   assign ex_rs1_data = ex_rs1_data_q;
   assign ex_rs2_data = ex_rs2_data_q;
   assign ex_imm      = ex_imm_q;

endmodule
